// File: rtl/pump_driver_ctrl.sv
// Pump driver controller: synchronises and debounces the active-low sensor line,
// then runs the pump FSM with minimum-on, maximum-on fault and cooldown timing.
module pump_driver_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned MIN_ON_CYCLES   = 25000000,
    parameter int unsigned MAX_ON_CYCLES   = 750000000,
    parameter int unsigned COOLDOWN_CYCLES = 125000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_col_n,
    input  logic       enable,
    input  logic       fault_clr,
    output logic       pump_base,
    output logic       led_pump,
    output logic       led_fault,
    output logic [1:0] state_o
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RUN_W = $clog2(MAX_ON_CYCLES) + 1;
    localparam int unsigned CD_W  = $clog2(COOLDOWN_CYCLES) + 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RUN_W-1:0] MIN_LAST = RUN_W'(MIN_ON_CYCLES - 1);
    localparam logic [RUN_W-1:0] MAX_LAST = RUN_W'(MAX_ON_CYCLES - 1);
    localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN      = 2'b01,
        ST_COOLDOWN = 2'b10,
        ST_FAULT    = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             dry_db_q, dry_db_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [CD_W-1:0]  cd_cnt_q, cd_cnt_d;
    logic             pump_q, pump_d;
    logic             fault_q, fault_d;

    always_comb begin
        s1_d = sensor_col_n;
        s2_d = s1_q;

        dry_db_d = dry_db_q;
        db_cnt_d = db_cnt_q;
        if (s2_q == dry_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            dry_db_d = s2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end

        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        cd_cnt_d  = cd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && dry_db_q) begin
                    state_d   = ST_RUN;
                    run_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (run_cnt_q != MAX_LAST) begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
                // A wet sensor at max expiry wins over the fault exit.
                if (!enable) begin
                    state_d  = ST_COOLDOWN;
                    cd_cnt_d = '0;
                end else if (run_cnt_q >= MIN_LAST && !dry_db_q) begin
                    state_d  = ST_COOLDOWN;
                    cd_cnt_d = '0;
                end else if (run_cnt_q == MAX_LAST && dry_db_q) begin
                    state_d = ST_FAULT;
                end
            end
            ST_COOLDOWN: begin
                if (cd_cnt_q == CD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cd_cnt_d = cd_cnt_q + CD_W'(1);
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d  = ST_COOLDOWN;
                    cd_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pump_d  = (state_d == ST_RUN);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            dry_db_q  <= 1'b0;
            db_cnt_q  <= '0;
            run_cnt_q <= '0;
            cd_cnt_q  <= '0;
            pump_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            dry_db_q  <= dry_db_d;
            db_cnt_q  <= db_cnt_d;
            run_cnt_q <= run_cnt_d;
            cd_cnt_q  <= cd_cnt_d;
            pump_q    <= pump_d;
            fault_q   <= fault_d;
        end
    end

    assign pump_base = pump_q;
    assign led_pump  = pump_q;
    assign led_fault = fault_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pump_driver_ctrl.sv
// Scoreboard bench for pump_driver_ctrl: the driver queues the expected outputs for
// each clock edge from the documented timing, the monitor pops and compares them.
module tb_pump_driver_ctrl;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] COOL = 2'b10;
    localparam logic [1:0] FLT  = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       sensor_col_n;
    logic       enable;
    logic       fault_clr;
    logic       pump_base;
    logic       led_pump;
    logic       led_fault;
    logic [1:0] state_o;

    int unsigned errors = 0;
    int unsigned checks = 0;
    string       phase  = "init";

    logic [4:0] exp_q[$];

    pump_driver_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .MIN_ON_CYCLES  (8),
        .MAX_ON_CYCLES  (32),
        .COOLDOWN_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor_col_n(sensor_col_n),
        .enable      (enable),
        .fault_clr   (fault_clr),
        .pump_base   (pump_base),
        .led_pump    (led_pump),
        .led_fault   (led_fault),
        .state_o     (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [4:0] expect_for(input logic [1:0] st);
        logic p;
        logic f;
        p = (st == RUN);
        f = (st == FLT);
        return {p, p, f, st};
    endfunction

    // Queue the expected outputs for the next n edges, advancing to each following negedge.
    task automatic cyc(input int n, input logic [1:0] st);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(expect_for(st));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(phase, {27'd0, pump_base, led_pump, led_fault, state_o}, {27'd0, e});
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        sensor_col_n = 1'b0;
        enable       = 1'b1;
        fault_clr    = 1'b0;
        #1;
        check("reset", {27'd0, pump_base, led_pump, led_fault, state_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        phase = "post_reset";
        cyc(3, IDLE);

        phase = "nominal";
        sensor_col_n = 1'b1;
        cyc(6, IDLE);
        cyc(20, RUN);
        sensor_col_n = 1'b0;
        cyc(6, RUN);
        cyc(16, COOL);
        cyc(3, IDLE);

        phase = "glitch";
        fault_clr = 1'b1;
        for (int r = 0; r < 5; r++) begin
            sensor_col_n = 1'b1;
            cyc(3, IDLE);
            sensor_col_n = 1'b0;
            cyc(3, IDLE);
        end
        fault_clr = 1'b0;
        cyc(2, IDLE);

        phase = "min_on";
        sensor_col_n = 1'b1;
        cyc(6, IDLE);
        cyc(1, RUN);
        sensor_col_n = 1'b0;
        cyc(7, RUN);
        cyc(16, COOL);
        cyc(2, IDLE);

        phase = "max_on";
        sensor_col_n = 1'b1;
        cyc(6, IDLE);
        cyc(32, RUN);
        phase = "fault_hold";
        cyc(40, FLT);
        enable = 1'b0;
        cyc(10, FLT);
        enable = 1'b1;
        cyc(50, FLT);
        phase = "fault_clr";
        fault_clr = 1'b1;
        cyc(1, COOL);
        fault_clr = 1'b0;
        cyc(15, COOL);
        cyc(1, IDLE);
        cyc(1, RUN);

        phase = "enable_drop";
        cyc(2, RUN);
        enable = 1'b0;
        cyc(16, COOL);
        cyc(4, IDLE);
        enable = 1'b1;
        cyc(1, RUN);
        cyc(3, RUN);

        phase = "async_reset";
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {27'd0, pump_base, led_pump, led_fault, state_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(6, IDLE);
        cyc(1, RUN);

        phase = "wet_at_max";
        cyc(25, RUN);
        sensor_col_n = 1'b0;
        cyc(6, RUN);
        cyc(16, COOL);
        cyc(2, IDLE);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pump_driver_ctrl.md
Name: pump_driver_ctrl

Overview:
- Actuator-side counterpart to the moisture-sensor front end: reads the active-low NPN-collector sensor line and drives the base of an NPN pump-driver transistor (active-high) on the Colorlight i9.
- Synchronises and debounces the sensor, then runs a pump FSM with minimum-on, maximum-on (fault) and cooldown timing.
- Exposes status for board LEDs.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before the debounced sensor level changes (≥1)
MIN_ON_CYCLES, 25000000, minimum pump-on duration in clocks (≥1)
MAX_ON_CYCLES, 750000000, maximum pump-on duration before FAULT (>MIN_ON_CYCLES)
COOLDOWN_CYCLES, 125000000, pump-off rest duration after every run or fault clear (≥1)

Ports:
clk  in  1  system clock (25 MHz on board)
rst_n  in  1  asynchronous active-low reset
sensor_col_n  in  1  asynchronous collector line; 0 = wet, 1 = dry
enable  in  1  synchronous master enable; 0 forces pump off
fault_clr  in  1  synchronous single-cycle fault acknowledge
pump_base  out  1  transistor base drive; 1 = pump on
led_pump  out  1  mirror of pump_base
led_fault  out  1  1 while in FAULT
state_o  out  2  FSM state: IDLE=00, RUN=01, COOLDOWN=10, FAULT=11

Behaviour:
- Reset (async, rst_n=0):
  - pump_base=0, led_pump=0, led_fault=0, state_o=00.
  - Sync flops=0 (wet), dry_db=0, all counters 0.
  - Asserting reset mid-RUN turns the pump off immediately, without waiting for a clock edge.
- Sync: two-flop synchroniser s1→s2 on sensor_col_n.
- Debounce:
  - If s2==dry_db, cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1, dry_db<=s2 and cnt<=0.
  - Else cnt++.
  - Any bounce restarts the count.
  - Latency: dry_db changes on edge 2+DEBOUNCE_CYCLES, counting edge 1 as the first edge that samples the new pin level.
- FSM: registered state. pump_base, led_pump, led_fault and state_o are registered from next-state, so they are glitch-free and change on the same edge as the state.
- IDLE:
  - Pump off.
  - enable && dry_db → RUN, run_cnt<=0.
- RUN: pump on; run_cnt++ each cycle. Exit priority, highest first:
  1. !enable → COOLDOWN. This overrides MIN_ON.
  2. run_cnt==MIN_ON_CYCLES-1 or later, and !dry_db → COOLDOWN.
  3. run_cnt==MAX_ON_CYCLES-1 and dry_db → FAULT.
  - Otherwise stay in RUN.
  - Result: the pump is on for at least MIN_ON_CYCLES cycles (unless enable drops) and at most MAX_ON_CYCLES cycles.
  - If wet and max expiry coincide on the same cycle, the exit goes to COOLDOWN, not FAULT.
- COOLDOWN:
  - Pump off; cd_cnt counts from 0.
  - At cd_cnt==COOLDOWN_CYCLES-1 → IDLE, so the rest lasts exactly COOLDOWN_CYCLES cycles.
  - The enable and sensor inputs are ignored.
- FAULT:
  - Pump off, led_fault=1.
  - fault_clr=1 → COOLDOWN. Otherwise hold the state indefinitely.
  - fault_clr in any other state is ignored.
  - enable does not clear a fault.
- Latency: pin dry→wet change to pump_base fall (past MIN_ON) is DEBOUNCE_CYCLES+3 edges. The dry→pump_base rise from IDLE has the same latency.
- Widths: each counter is $clog2(param)+1 bits. Counters never wrap; they reset on state entry.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, MIN_ON_CYCLES=8, MAX_ON_CYCLES=32, COOLDOWN_CYCLES=16; enable=1 unless stated.)
1. Nominal cycle: sensor_col_n 0→1 → pump_base rises on edge 7 (state_o=01). Pin →0 after 20 RUN cycles → pump_base falls 7 edges later, state_o=10 for exactly 16 cycles, then 00.
2. Glitch rejection: pin dry for 3 cycles then wet, repeated 5 times → dry_db stays 0, pump_base stays 0, state_o=00 throughout.
3. Min-on: pin dry long enough to start RUN, then wet 1 cycle after entry → pump_base high exactly 8 cycles, then COOLDOWN.
4. Max-on fault: pin held dry → pump_base high exactly 32 cycles, then state_o=11, led_fault=1, and both hold for 100 cycles. A fault_clr pulse gives 16 COOLDOWN cycles, then IDLE, then RUN on the next edge (still dry).
5. Enable drop: enable→0 on RUN cycle 3 → pump_base 0 next edge, COOLDOWN 16 cycles. With enable still 0 the block stays in IDLE; enable→1 → RUN next edge.
6. Async reset: rst_n→0 mid-RUN between clock edges → pump_base=0 and state_o=00 immediately. After release with pin dry → RUN after 7 edges.
